// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encoding and
// hold-counter sizing.
package mux_arbiter_pkg;

   localparam int unsigned HOLD_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   typedef logic [HOLD_W-1:0] hold_t;

   localparam hold_t HOLD_SAT = '1;

endpackage

// File: rtl/mux_arbiter_mux2.sv
// Combinational WIDTH-bit 2:1 mux; switch=1 selects i1.
module mux2 #(
   parameter int unsigned WIDTH = 8
) (
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             switch
);

   always_comb begin
      out = switch ? i1 : i0;
   end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with bounded hold time, forwarding the granted
// requester's data through a registered 2:1 mux.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             grant0,
   output logic             grant1,
   output logic             switch,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   localparam hold_t HOLD_LIMIT = hold_t'(MAX_HOLD - 1);

   state_t           state;
   state_t           state_nxt;
   hold_t            hold;
   logic             last;
   logic             turn_over;
   logic [WIDTH-1:0] mux_out;

   mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .out    (mux_out),
      .i0     (data0),
      .i1     (data1),
      .switch (switch)
   );

   // >= rather than == so a requester arriving after a long solo hold
   // (counter already past the limit) is still turned over promptly.
   assign turn_over = (hold >= HOLD_LIMIT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         hold      <= '0;
         last      <= 1'b1;
         switch    <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state != IDLE);
         if (state != IDLE) begin
            out <= mux_out;
         end
         if (state_nxt != IDLE && state_nxt != state) begin
            hold   <= '0;
            last   <= (state_nxt == GRANT1);
            switch <= (state_nxt == GRANT1);
         end else if (state_nxt != IDLE && hold != HOLD_SAT) begin
            hold <= hold + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = last ? GRANT0 : GRANT1;
            end else if (req0) begin
               state_nxt = GRANT0;
            end else if (req1) begin
               state_nxt = GRANT1;
            end
         end
         GRANT0: begin
            if (!req0) begin
               state_nxt = req1 ? GRANT1 : IDLE;
            end else if (req1 && turn_over) begin
               state_nxt = GRANT1;
            end
         end
         GRANT1: begin
            if (!req1) begin
               state_nxt = req0 ? GRANT0 : IDLE;
            end else if (req0 && turn_over) begin
               state_nxt = GRANT0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant0 = (state == GRANT0);
      grant1 = (state == GRANT1);
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: a behavioural owner/streak model predicts
// each edge's outputs, and a monitor pops and compares them.
module tb_mux_arbiter;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned MAX_HOLD = 4;

   logic             clock;
   logic             reset;
   logic             req0, req1;
   logic [WIDTH-1:0] data0, data1;
   logic             grant0, grant1, switch, out_valid;
   logic [WIDTH-1:0] out;

   typedef struct packed {
      logic             g0;
      logic             g1;
      logic             sw;
      logic             v;
      logic [WIDTH-1:0] o;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;

   // model: owner -1 = nobody, streak = cycles the owner has held so far
   int               owner;
   int               streak;
   int               lastw;
   logic             m_sw;
   logic [WIDTH-1:0] m_out;
   logic             m_v;

   mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clock     (clock),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .grant0    (grant0),
      .grant1    (grant1),
      .switch    (switch),
      .out       (out),
      .out_valid (out_valid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      owner  = -1;
      streak = 0;
      lastw  = 1;
      m_sw   = 1'b0;
      m_out  = '0;
      m_v    = 1'b0;
   endtask

   // Predict outputs after the next rising edge from the inputs now driven.
   task automatic model_step();
      int   nxt;
      exp_t e;
      m_v = (owner != -1);
      if (owner == 0) m_out = data0;
      else if (owner == 1) m_out = data1;
      if (owner == -1) begin
         if (req0 && req1) nxt = 1 - lastw;
         else if (req0) nxt = 0;
         else if (req1) nxt = 1;
         else nxt = -1;
      end else begin
         logic mine, other;
         mine  = (owner == 0) ? req0 : req1;
         other = (owner == 0) ? req1 : req0;
         if (!mine) nxt = other ? 1 - owner : -1;
         else if (other && streak >= int'(MAX_HOLD)) nxt = 1 - owner;
         else nxt = owner;
      end
      if (nxt != -1 && nxt != owner) begin
         streak = 1;
         lastw  = nxt;
         m_sw   = (nxt == 1);
      end else if (nxt != -1) begin
         streak++;
      end
      owner = nxt;
      e.g0 = (owner == 0);
      e.g1 = (owner == 1);
      e.sw = m_sw;
      e.v  = m_v;
      e.o  = m_out;
      expq.push_back(e);
   endtask

   task automatic drive(input logic r0, input logic r1, input logic [WIDTH-1:0] d0,
                        input logic [WIDTH-1:0] d1);
      @(posedge clock);
      #1;
      req0  = r0;
      req1  = r1;
      data0 = d0;
      data1 = d1;
      model_step();
   endtask

   function automatic logic [WIDTH-1:0] rnd();
      return WIDTH'($urandom);
   endfunction

   task automatic check_reset_values();
      chk("rst_grant0", {31'b0, grant0}, 0);
      chk("rst_grant1", {31'b0, grant1}, 0);
      chk("rst_switch", {31'b0, switch}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out", {24'b0, out}, 0);
   endtask

   // Monitor: one expectation per rising edge while enabled.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (mon_en) begin
            chk("onehot", {31'b0, grant0 & grant1}, 0);
            if (expq.size() == 0) begin
               chk("queue_underflow", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("grant0", {31'b0, grant0}, {31'b0, e.g0});
               chk("grant1", {31'b0, grant1}, {31'b0, e.g1});
               chk("switch", {31'b0, switch}, {31'b0, e.sw});
               chk("out_valid", {31'b0, out_valid}, {31'b0, e.v});
               chk("out", {24'b0, out}, {24'b0, e.o});
            end
         end
      end
   end

   initial begin
      logic r0, r1;
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      data0 = '0;
      data1 = '0;
      model_reset();
      #1;
      check_reset_values();

      // single requester with fixed data
      repeat (2) @(negedge clock);
      req0  = 1'b1;
      data0 = 8'hA5;
      data1 = 8'h3C;
      reset = 1'b1;
      model_step();
      mon_en = 1'b1;
      repeat (5) drive(1'b1, 1'b0, 8'hA5, rnd());
      repeat (2) drive(1'b0, 1'b0, rnd(), rnd());

      // tie, then handoff GRANT1 -> GRANT0 by dropping req1
      repeat (20) drive(1'b1, 1'b1, rnd(), rnd());
      repeat (3) drive(1'b0, 1'b1, rnd(), rnd());
      repeat (3) drive(1'b1, 1'b0, rnd(), rnd());
      repeat (2) drive(1'b0, 1'b0, rnd(), rnd());

      // random request levels with sticky toggling
      r0 = 1'b0;
      r1 = 1'b0;
      for (int unsigned i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) r0 = ~r0;
         if ($urandom_range(3) == 0) r1 = ~r1;
         drive(r0, r1, rnd(), rnd());
      end

      // reset 3 ns into a GRANT1 cycle
      repeat (3) drive(1'b0, 1'b1, rnd(), rnd());
      @(posedge clock);
      #3;
      chk("pre_rst_grant1", {31'b0, grant1}, 1);
      mon_en = 1'b0;
      reset  = 1'b0;
      expq.delete();
      model_reset();
      #1;
      check_reset_values();
      req0 = 1'b1;
      req1 = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_step();
      mon_en = 1'b1;
      repeat (16) drive(1'b1, 1'b1, rnd(), rnd());
      repeat (3) drive(1'b0, 1'b0, rnd(), rnd());

      @(posedge clock);
      #3;
      mon_en = 1'b0;
      chk("queue_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
